// File: rtl/fsm_stim_tx.sv
// fsm_stim_tx: serial pattern transmitter for single-bit-input Moore sequence detectors.
//
// A word is accepted over a valid/ready handshake while idle. The machine then pulses
// seq_rst_o for one cycle and shifts the word out LSB-first, one bit per clock, with
// bit_valid_o qualifying each bit. frame_done_o pulses once after the last bit.
//
// Optional feature (macro FSM_STIM_TX_PARITY_EN): an even-parity bit is appended
// after the payload in a dedicated PAR state. A frame then lasts WIDTH+4 cycles
// instead of WIDTH+3.
//
// Parameters:
//   WIDTH         bits per frame, 2..32
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset; aborts any frame in flight
//   word_in_i     frame payload, sampled only on an accepted handshake
//   word_valid_i  producer has a word on word_in_i
//   word_ready_o  block can accept a word (IDLE only)
//   seq_rst_o     one-cycle reset pulse per frame for the downstream detector
//   b_out_o       serial data bit
//   bit_valid_o   b_out_o carries a payload (or parity) bit
//   busy_o        high in every state except IDLE
//   frame_done_o  one-cycle pulse after the last transmitted bit
module fsm_stim_tx #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] word_in_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  output logic             seq_rst_o,
  output logic             b_out_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef FSM_STIM_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StSync, StShift, StPar, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StSync, StShift, StDone} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             word_ready_q;
  logic             seq_rst_q;
  logic             b_out_q;
  logic             bit_valid_q;
  logic             busy_q;
  logic             frame_done_q;
`ifdef FSM_STIM_TX_PARITY_EN
  logic             par_q;
`endif

  // Shift register contents after this edge's shift; its LSB is the next bit on the wire.
  logic [WIDTH-1:0] shreg_shr;
  assign shreg_shr = shreg_q >> 1;

  // Outputs are registered alongside the state, so each one is loaded with the value
  // the destination state decodes to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      word_ready_q <= 1'b1;
      seq_rst_q    <= 1'b0;
      b_out_q      <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FSM_STIM_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (word_valid_i) begin
            state_q      <= StSync;
            shreg_q      <= word_in_i;
            cnt_q        <= '0;
            word_ready_q <= 1'b0;
            seq_rst_q    <= 1'b1;
            busy_q       <= 1'b1;
`ifdef FSM_STIM_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
          end
        end
        StSync: begin
          state_q     <= StShift;
          seq_rst_q   <= 1'b0;
          bit_valid_q <= 1'b1;
          b_out_q     <= shreg_q[0];
        end
        StShift: begin
          shreg_q <= shreg_shr;
`ifdef FSM_STIM_TX_PARITY_EN
          par_q   <= par_q ^ shreg_q[0];
`endif
          if (cnt_q == CntLast) begin
            // Counter holds at its last value so it never wraps inside a frame.
`ifdef FSM_STIM_TX_PARITY_EN
            state_q      <= StPar;
            b_out_q      <= par_q ^ shreg_q[0];
`else
            state_q      <= StDone;
            bit_valid_q  <= 1'b0;
            b_out_q      <= 1'b0;
            frame_done_q <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            b_out_q <= shreg_shr[0];
          end
        end
`ifdef FSM_STIM_TX_PARITY_EN
        StPar: begin
          state_q      <= StDone;
          bit_valid_q  <= 1'b0;
          b_out_q      <= 1'b0;
          frame_done_q <= 1'b1;
        end
`endif
        StDone: begin
          state_q      <= StIdle;
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          word_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= StIdle;
          word_ready_q <= 1'b1;
          seq_rst_q    <= 1'b0;
          b_out_q      <= 1'b0;
          bit_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready_o = word_ready_q;
  assign seq_rst_o    = seq_rst_q;
  assign b_out_o      = b_out_q;
  assign bit_valid_o  = bit_valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fsm_stim_tx.sv
// Directed testbench for fsm_stim_tx (WIDTH = 32). Each observation point packs the
// outputs as {word_ready, busy, bit_valid, seq_rst, frame_done, b_out}.
module tb_fsm_stim_tx;

  localparam int unsigned W = 32;
`ifdef FSM_STIM_TX_PARITY_EN
  localparam int FrameLen = W + 4;
`else
  localparam int FrameLen = W + 3;
`endif

  localparam logic [5:0] VIdle = 6'b100000;
  localparam logic [5:0] VSync = 6'b010100;
  localparam logic [5:0] VDone = 6'b010010;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready, seq_rst, b_out, bit_valid, busy, frame_done;

  int n_assert = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int acc_prev = 0;

  fsm_stim_tx #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .word_in_i    (word_in),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .seq_rst_o    (seq_rst),
    .b_out_o      (b_out),
    .bit_valid_o  (bit_valid),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {word_ready, busy, bit_valid, seq_rst, frame_done, b_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Advance past one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Transmit one frame and check every cycle of it. mid_w is put on word_in right after
  // the accept; keep_valid leaves word_valid high for a back-to-back follow-up. When
  // gap_chk is set the accept must land exactly one frame after the previous accept.
  task automatic frame(input logic [W-1:0] w, input logic [W-1:0] mid_w,
                       input bit keep_valid, input bit gap_chk);
    logic p;
    p = 1'b0;
    word_in = w;
    word_valid = 1'b1;
    step();
    if (gap_chk) chk("accept_gap", edge_cnt - acc_prev, FrameLen);
    acc_prev = edge_cnt;
    chk("sync", {26'd0, obs()}, {26'd0, VSync});
    word_in = mid_w;
    word_valid = keep_valid;
    for (int k = 0; k < int'(W); k++) begin
      step();
      chk($sformatf("bit%0d", k), {26'd0, obs()}, {26'd0, 5'b01100, w[k]});
      p = p ^ w[k];
    end
`ifdef FSM_STIM_TX_PARITY_EN
    step();
    chk("parity", {26'd0, obs()}, {26'd0, 5'b01100, p});
`endif
    step();
    chk("done", {26'd0, obs()}, {26'd0, VDone});
    step();
    chk("idle_after", {26'd0, obs()}, {26'd0, VIdle});
  endtask

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1 chk("reset_async", {26'd0, obs()}, {26'd0, VIdle});
    step();
    chk("reset_hold", {26'd0, obs()}, {26'd0, VIdle});
    rst = 1'b0;

    // Idle hold: no valid for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_hold", {26'd0, obs()}, {26'd0, VIdle});
    end

    // Single set bit, then an irregular pattern (first bits 0,1,1,1,0,0,1,0).
    frame(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    frame(32'h93AA_574E, 32'h1234_5678, 1'b0, 1'b0);

    // Back-to-back; word_in changes to zero during frame 1 without affecting it.
    frame(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    frame(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);

    // Reset mid-frame, asserted between edges after the 10th bit_valid cycle.
    word_in = 32'hDEAD_BEEF;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("pre_abort_bit9", {26'd0, obs()}, {26'd0, 5'b01100, 1'b1});
    #2 rst = 1'b1;
    #1 chk("abort_async", {26'd0, obs()}, {26'd0, VIdle});
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("abort_no_done", {26'd0, obs()}, {26'd0, VIdle});
    end
    frame(32'hA5C3_1E7F, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Parity cases (parity bits 1 and 0 when the feature is built in).
    frame(32'h93AA_574E, 32'h0000_0000, 1'b1, 1'b0);
    frame(32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_stim_tx.md
Name: fsm_stim_tx

Overview:
- Synthesizable serial pattern transmitter that feeds the team's single-bit-input Moore sequence detectors.
- Accepts a parallel word over a valid/ready handshake, pulses a per-frame sequence reset, then shifts the word out LSB-first on one bit per clock with a qualifying strobe.
- Sits upstream of the detector: drives its serial input `b` and its `rst`. It is the hardware replacement for bench-driven stimulus on the board.

Parameters:
- WIDTH, 32: bits per frame; legal range 2..32; bit counter width is $clog2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- word_in  in  WIDTH  frame payload; sampled only on an accepted handshake
- word_valid  in  1  producer has a word on word_in
- word_ready  out  1  block can accept a word; high only in IDLE
- seq_rst  out  1  reset pulse for the downstream detector; one cycle per frame
- b_out  out  1  serial data bit
- bit_valid  out  1  b_out carries a payload bit (or the parity bit when enabled)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last transmitted bit

Behaviour:
- Moore machine. All outputs are decoded from the state register and the shift register only, with no combinational path from inputs.
- States:
  - IDLE: word_ready=1; all other outputs 0.
  - SYNC: seq_rst=1, busy=1, bit_valid=0, b_out=0.
  - SHIFT: bit_valid=1, b_out=shreg[0], busy=1.
  - PAR: exists only with the optional feature.
  - DONE: frame_done=1, busy=1, b_out=0.
- Reset: asserting rst immediately forces IDLE, shreg=0, cnt=0, word_ready=1, and all other outputs 0, without waiting for a clock edge. Reset during any state aborts the frame and discards the word; no frame_done is produced.
- Transitions:
  - IDLE→SYNC on a rising edge with word_valid=1. That edge latches word_in into shreg and clears cnt.
  - SYNC→SHIFT unconditionally.
  - SHIFT: each edge shifts shreg right by 1 (zero-fill) and increments cnt.
  - When cnt==WIDTH-1 at an edge, the machine goes to DONE (or to PAR when the feature is enabled).
  - PAR→DONE unconditionally.
  - DONE→IDLE unconditionally.
- Timing, counting the accept edge as edge 0:
  - seq_rst is high between edges 0 and 1.
  - Payload bit k is valid between edges k+1 and k+2.
  - frame_done is high between edges WIDTH+1 and WIDTH+2.
- Throughput: with word_valid held high, successive accepts are exactly WIDTH+3 edges apart (WIDTH+4 with parity).
- Boundary conditions:
  - word_valid and word_in are ignored outside IDLE. A word changing mid-frame does not corrupt the frame in flight.
  - word_valid deasserted in IDLE: the machine stays in IDLE indefinitely with outputs stable.
  - The counter never wraps inside a frame. It is cleared on accept and on reset.

Optional Feature:
- Macro: FSM_STIM_TX_PARITY_EN.
- Defined:
  - After the last payload bit, the machine enters PAR for one cycle with bit_valid=1 and b_out = XOR of all WIDTH payload bits (even parity).
  - The parity is computed as a running XOR during SHIFT; it is reset to 0 on accept and on rst.
  - Frame length becomes WIDTH+4 cycles.
- Undefined: the PAR state, the parity register and the logic feeding them are absent, and SHIFT goes directly to DONE.

Test Plan:
- Single bit: rst pulse, then word_in=32'h0000_0001 with word_valid=1 for one cycle → one cycle of seq_rst=1, then 32 cycles of bit_valid=1 with b_out=1 followed by 31 zeros, then frame_done high for exactly one cycle, then word_ready=1.
- Pattern order: word_in=32'h93AA_574E → first eight b_out values 0,1,1,1,0,0,1,0 (LSB-first); 32 bit_valid cycles in total.
- Back-to-back: word_valid held high with words 32'hFFFF_FFFF then 32'h0000_0000 → accepts exactly 35 edges apart; seq_rst pulses once per frame; no gap or duplicate bit; the word_in change during frame 1 has no effect on frame 1.
- Reset mid-frame: assert rst after the 10th bit_valid cycle, asynchronously mid-cycle → b_out, bit_valid, busy and seq_rst go to 0 before the next edge; no frame_done; the next accepted word transmits cleanly from bit 0.
- Idle hold: word_valid=0 for 50 cycles after reset → word_ready=1, busy=0, bit_valid=0, seq_rst=0 throughout.
- Parity (FSM_STIM_TX_PARITY_EN defined): word 32'h93AA_574E (17 ones) → 33rd bit_valid cycle carries b_out=1; the next accept is 36 edges after the first. Word 32'h0000_0003 → parity bit 0.
